// File: rtl/aes_ctr_sequencer.sv
// Counter-mode sequencer: pairs FIFO plaintext with core keystream for {nonce, ctr} blocks.
// Optional WAIT-state watchdog is compiled in with `define AES_SEQ_TIMEOUT_EN.
module aes_ctr_sequencer #(
    parameter int DATA_W  = 128,
    parameter int CTR_W   = 32,
    parameter int TIMEOUT = 63
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              cfg_valid,
    input  logic [DATA_W-1:0] nonce_in,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic              core_go,
    output logic [DATA_W-1:0] core_block,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_enc,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              err,
    output logic [CTR_W-1:0]  blk_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t                   state_r;
    state_t                   state_s;
    logic [DATA_W-CTR_W-1:0]  nonce_hi_r;
    logic [CTR_W-1:0]         ctr_r;
    logic [CTR_W-1:0]         init_ctr_r;
    logic [CTR_W-1:0]         blk_count_r;
    logic [CTR_W-1:0]         ctr_inc_s;
    logic [CTR_W-1:0]         ctr_after_s;
    logic [DATA_W-1:0]        out_data_r;
    logic                     first_r;
    logic                     fifo_rd_r;
    logic                     core_go_r;
    logic                     out_valid_r;
    logic                     busy_r;
    logic                     latch_s;
    logic                     capture_s;
    logic                     timeout_s;

    if (TIMEOUT < 1) begin : g_timeout_chk
        $error("aes_ctr_sequencer: TIMEOUT must be at least 1");
    end

`ifdef AES_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt_r;
    logic            err_r;

    assign timeout_s = (wd_cnt_r == WD_W'(TIMEOUT - 1));
    assign err       = err_r;

    // Watchdog: counts consecutive WAIT cycles; err stays set until cfg_valid in ERROR
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wd_cnt_r <= {WD_W{1'b0}};
            err_r    <= 1'b0;
        end else begin
            if ((state_r == S_WAIT) && (state_s == S_WAIT)) begin
                wd_cnt_r <= wd_cnt_r + 1'b1;
            end else begin
                wd_cnt_r <= {WD_W{1'b0}};
            end
            if ((state_r == S_WAIT) && (state_s == S_ERROR)) begin
                err_r <= 1'b1;
            end else if ((state_r == S_ERROR) && (state_s == S_ARMED)) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
        end
    end
`else
    assign timeout_s = 1'b0;
    assign err       = 1'b0;
`endif

    // Next-state decode; the wrap test looks at the counter value after this block's increment
    always_comb begin
        state_s     = state_r;
        latch_s     = 1'b0;
        capture_s   = 1'b0;
        ctr_inc_s   = ctr_r + 1'b1;
        ctr_after_s = first_r ? ctr_inc_s : ctr_r;
        case (state_r)
            S_IDLE: begin
                if (cfg_valid) begin
                    latch_s = 1'b1;
                    state_s = S_ARMED;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ARMED: begin
                if (cfg_valid) begin
                    latch_s = 1'b1;
                    state_s = S_ARMED;
                end else if (!fifo_empty) begin
                    state_s = S_START;
                end else begin
                    state_s = S_ARMED;
                end
            end
            S_START: begin
                state_s = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    capture_s = 1'b1;
                    state_s   = S_OUT;
                end else if (timeout_s) begin
                    state_s = S_ERROR;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (ctr_after_s == init_ctr_r) begin
                        state_s = S_IDLE;
                    end else begin
                        state_s = S_ARMED;
                    end
                end else begin
                    state_s = S_OUT;
                end
            end
            S_ERROR: begin
                if (cfg_valid) begin
                    latch_s = 1'b1;
                    state_s = S_ARMED;
                end else begin
                    state_s = S_ERROR;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs (outputs decoded from the next state)
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r     <= S_IDLE;
            nonce_hi_r  <= {(DATA_W-CTR_W){1'b0}};
            ctr_r       <= {CTR_W{1'b0}};
            init_ctr_r  <= {CTR_W{1'b0}};
            blk_count_r <= {CTR_W{1'b0}};
            out_data_r  <= {DATA_W{1'b0}};
            first_r     <= 1'b0;
            fifo_rd_r   <= 1'b0;
            core_go_r   <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            first_r     <= capture_s;
            fifo_rd_r   <= capture_s && !fifo_empty;
            core_go_r   <= (state_s == S_START);
            out_valid_r <= (state_s == S_OUT);
            busy_r      <= !((state_s == S_IDLE) || (state_s == S_ARMED));
            if (latch_s) begin
                nonce_hi_r  <= nonce_in[DATA_W-1:CTR_W];
                ctr_r       <= nonce_in[CTR_W-1:0];
                init_ctr_r  <= nonce_in[CTR_W-1:0];
                blk_count_r <= {CTR_W{1'b0}};
            end else if (first_r) begin
                ctr_r       <= ctr_inc_s;
                blk_count_r <= blk_count_r + 1'b1;
            end else begin
                ctr_r       <= ctr_r;
                blk_count_r <= blk_count_r;
            end
            if (capture_s) begin
                out_data_r <= core_enc ^ fifo_data;
            end else begin
                out_data_r <= out_data_r;
            end
        end
    end

    assign fifo_rd    = fifo_rd_r;
    assign core_go    = core_go_r;
    assign core_block = {nonce_hi_r, ctr_r};
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign busy       = busy_r;
    assign blk_count  = blk_count_r;

endmodule

// File: tb/tb_aes_ctr_sequencer.sv
// Scoreboard bench for aes_ctr_sequencer: a 128/32 instance and a 16/4 instance for counter wrap.
module tb_aes_ctr_sequencer;
    localparam int TIMEOUT = 63;
    localparam logic [127:0] MASK = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
    localparam logic [127:0] N1   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_0000_0005;
    localparam logic [127:0] PT1  = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    localparam logic [127:0] N2   = 128'hDEAD_BEEF_0000_1111_2222_3333_FFFF_FFFE;
    localparam logic [127:0] N4   = 128'h0000_0000_0000_0000_0000_0000_0000_123F;
    localparam logic [127:0] M16  = 128'h0000_0000_0000_0000_0000_0000_0000_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         HRESETn    = 1'b0;
    logic         cfg_valid  = 1'b0;
    logic [127:0] nonce_in   = 128'h0;
    logic         fifo_empty = 1'b1;
    logic [127:0] fifo_data  = 128'h0;
    logic         core_done  = 1'b0;
    logic [127:0] core_enc   = 128'h0;
    logic         out_ready  = 1'b1;
    logic         sel        = 1'b0;

    logic         rd_a, go_a, ov_a, busy_a, err_a;
    logic [127:0] cb_a, od_a;
    logic [31:0]  bc_a;
    logic         rd_b, go_b, ov_b, busy_b, err_b;
    logic [15:0]  cb_b, od_b;
    logic [3:0]   bc_b;

    aes_ctr_sequencer #(.DATA_W(128), .CTR_W(32), .TIMEOUT(TIMEOUT)) dut_a (
        .HCLK(clk), .HRESETn(HRESETn), .cfg_valid(cfg_valid), .nonce_in(nonce_in),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd(rd_a), .core_go(go_a),
        .core_block(cb_a), .core_done(core_done), .core_enc(core_enc), .out_valid(ov_a),
        .out_data(od_a), .out_ready(out_ready), .busy(busy_a), .err(err_a), .blk_count(bc_a));

    aes_ctr_sequencer #(.DATA_W(16), .CTR_W(4), .TIMEOUT(TIMEOUT)) dut_b (
        .HCLK(clk), .HRESETn(HRESETn), .cfg_valid(cfg_valid), .nonce_in(nonce_in[15:0]),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data[15:0]), .fifo_rd(rd_b), .core_go(go_b),
        .core_block(cb_b), .core_done(core_done), .core_enc(core_enc[15:0]), .out_valid(ov_b),
        .out_data(od_b), .out_ready(out_ready), .busy(busy_b), .err(err_b), .blk_count(bc_b));

    logic         act_rd, act_go, act_ov, act_busy, act_err;
    logic [127:0] act_cb, act_od;
    logic [31:0]  act_bc;
    assign act_rd   = sel ? rd_b   : rd_a;
    assign act_go   = sel ? go_b   : go_a;
    assign act_ov   = sel ? ov_b   : ov_a;
    assign act_busy = sel ? busy_b : busy_a;
    assign act_err  = sel ? err_b  : err_a;
    assign act_cb   = sel ? {112'h0, cb_b} : cb_a;
    assign act_od   = sel ? {112'h0, od_b} : od_a;
    assign act_bc   = sel ? {28'h0, bc_b}  : bc_a;

    int checks = 0, errors = 0;
    int cyc = 0, go_cnt = 0, rd_cnt = 0, pres_cnt = 0, go_cyc = 0;
    int stall_pres = 0, stall_len = 0, stall_cnt = 0;
    int core_mode = 0, core_delay = 1;
    logic [127:0] fifo_q[$];
    logic [127:0] exp_blk_q[$];
    logic [127:0] exp_out_q[$];
    logic         ov_prev = 1'b0, err_prev = 1'b0;
    logic [127:0] od_prev = 128'h0;
    logic [127:0] core_blk = 128'h0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [127:0] n);
        nonce_in  = n;
        cfg_valid = 1'b1;
        tick(1);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        @(negedge clk);
        while (!(fifo_q.size() == 0 && !act_busy && !act_ov && exp_out_q.size() == 0) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(name, 128'(n < bound), 128'h1);
    endtask

    task automatic pulse_reset();
        HRESETn = 1'b0;
        tick(2);
        fifo_q.delete();
        HRESETn = 1'b1;
        tick(1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor/scoreboard plus FIFO and out_ready models, all on the falling edge
    initial forever begin
        @(negedge clk);
        if (HRESETn) begin
            if (stall_cnt > 0) begin
                stall_cnt--;
                if (stall_cnt == 0) out_ready = 1'b1;
            end
            if (act_go) begin
                go_cnt++;
                go_cyc = cyc;
                if (exp_blk_q.size() == 0) chk("core_block_unexpected_go", act_cb, 128'hX);
                else chk("core_block", act_cb, exp_blk_q.pop_front());
            end
            if (act_ov && !ov_prev) begin
                pres_cnt++;
                if (exp_out_q.size() == 0) chk("out_data_unexpected", act_od, 128'hX);
                else chk("out_data", act_od, exp_out_q.pop_front());
                if (pres_cnt == stall_pres) begin
                    out_ready = 1'b0;
                    stall_cnt = stall_len;
                end
            end else if (act_ov && ov_prev) begin
                chk("out_hold", act_od, od_prev);
            end
            if (act_rd) begin
                rd_cnt++;
                chk("fifo_rd_when_empty", 128'(fifo_empty), 128'h0);
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            end
`ifdef AES_SEQ_TIMEOUT_EN
            if (act_err && !err_prev) chk("err_latency", 128'(cyc), 128'(go_cyc + 1 + TIMEOUT));
`endif
        end
        ov_prev    = act_ov;
        od_prev    = act_od;
        err_prev   = act_err;
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 128'h0 : fifo_q[0];
    end

    // Encryption core model: keystream = block ^ MASK after core_delay cycles
    initial forever begin
        @(negedge clk);
        if (HRESETn && act_go) begin
            core_blk = act_cb;
            if (core_mode == 0) begin
                repeat (core_delay) @(posedge clk);
                #1;
                core_enc  = core_blk ^ MASK;
                core_done = 1'b1;
                @(posedge clk);
                #1 core_done = 1'b0;
                @(negedge clk);
                chk("done_to_valid", 128'(act_ov), 128'h1);
            end else if (core_mode == 2) begin
                core_enc  = {128{1'b1}};
                core_done = 1'b1;
                @(posedge clk);
                #1 core_done = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int g, r, p, n;
        logic [31:0]  c;
        logic [3:0]   c4;
        logic [127:0] blk, pt;

        // Reset held with cfg_valid asserted
        HRESETn   = 1'b0;
        cfg_valid = 1'b1;
        nonce_in  = {128{1'b1}};
        fifo_q.push_back(PT1);
        repeat (4) @(negedge clk);
        chk("rst_core_go", 128'(act_go), 128'h0);
        chk("rst_fifo_rd", 128'(act_rd), 128'h0);
        chk("rst_out_valid", 128'(act_ov), 128'h0);
        chk("rst_busy", 128'(act_busy), 128'h0);
        chk("rst_err", 128'(act_err), 128'h0);
        chk("rst_blk_count", 128'(act_bc), 128'h0);
        chk("rst_out_data", act_od, 128'h0);
        chk("rst_core_block", act_cb, 128'h0);
        fifo_q.delete();
        cfg_valid = 1'b0;
        tick(1);
        HRESETn = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 128'(act_busy), 128'h0);

        // One block, slow core
        core_delay = 40;
        do_cfg(N1);
        exp_blk_q.push_back(N1);
        exp_out_q.push_back(PT1 ^ N1 ^ MASK);
        r = rd_cnt;
        fifo_q.push_back(PT1);
        wait_idle("t1_idle", 200);
        chk("t1_blk_count", 128'(act_bc), 128'h1);
        chk("t1_fifo_rd_pulses", 128'(rd_cnt - r), 128'h1);
        chk("t1_next_ctr", 128'(act_cb[31:0]), 128'h6);
        chk("t1_next_nonce_hi", 128'(act_cb[127:32]), 128'(N1[127:32]));

        // Three blocks across the 2^32 counter boundary, block 2 stalled
        core_delay = 3;
        do_cfg(N2);
        stall_pres = pres_cnt + 2;
        stall_len  = 10;
        for (int i = 0; i < 3; i++) begin
            c   = 32'hFFFF_FFFE + 32'(i);
            blk = {N2[127:32], c};
            pt  = 128'h5555_AAAA_0000_FFFF_1234_5678_9ABC_DEF0 ^ 128'(i);
            exp_blk_q.push_back(blk);
            exp_out_q.push_back(pt ^ blk ^ MASK);
            fifo_q.push_back(pt);
        end
        n = 0;
        while (pres_cnt < stall_pres && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("t2_block2_presented", 128'(n < 300), 128'h1);
        g = go_cnt;
        repeat (5) @(negedge clk);
        chk("t2_no_go_during_stall", 128'(go_cnt), 128'(g));
        chk("t2_valid_held", 128'(act_ov), 128'h1);
        chk("t2_busy_in_out", 128'(act_busy), 128'h1);
        do_cfg(128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000);
        wait_idle("t2_idle", 300);
        chk("t2_blk_count", 128'(act_bc), 128'h3);
        chk("t2_ctr_after", 128'(act_cb[31:0]), 128'h1);
        stall_pres = 0;

        // Narrow instance: 16 blocks wrap the 4-bit counter back to its start
        pulse_reset();
        sel        = 1'b1;
        core_delay = 1;
        do_cfg(N4);
        for (int i = 0; i < 16; i++) begin
            c4  = 4'hF + 4'(i);
            blk = {112'h0, 12'h123, c4};
            pt  = {112'h0, 16'hC3A5 ^ 16'(i * 273)};
            exp_blk_q.push_back(blk);
            exp_out_q.push_back((pt ^ blk ^ MASK) & M16);
            fifo_q.push_back(pt);
        end
        wait_idle("t3_idle", 1500);
        chk("t3_busy", 128'(act_busy), 128'h0);
        chk("t3_blk_count_wrap", 128'(act_bc), 128'h0);
        chk("t3_ctr_back", act_cb, N4);
        g = go_cnt;
        r = rd_cnt;
        pt = {112'h0, 16'h7E81};
        fifo_q.push_back(pt);
        repeat (20) @(negedge clk);
        chk("t3_no_go_after_wrap", 128'(go_cnt), 128'(g));
        chk("t3_no_rd_after_wrap", 128'(rd_cnt), 128'(r));
        chk("t3_fifo_kept", 128'(fifo_q.size()), 128'h1);
        exp_blk_q.push_back(N4);
        exp_out_q.push_back((pt ^ N4 ^ MASK) & M16);
        do_cfg(N4);
        wait_idle("t3_reconf_idle", 200);
        chk("t3_blk_count_reconf", 128'(act_bc), 128'h1);

`ifdef AES_SEQ_TIMEOUT_EN
        // Core never answers: watchdog, then recovery through cfg_valid
        pulse_reset();
        sel       = 1'b0;
        core_mode = 1;
        do_cfg(N1);
        exp_blk_q.push_back(N1);
        r = rd_cnt;
        p = pres_cnt;
        fifo_q.push_back(PT1);
        n = 0;
        while (!act_err && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("t4_err_seen", 128'(act_err), 128'h1);
        chk("t4_no_valid", 128'(pres_cnt), 128'(p));
        chk("t4_no_rd", 128'(rd_cnt), 128'(r));
        chk("t4_busy_error", 128'(act_busy), 128'h1);
        core_mode  = 0;
        core_delay = 2;
        exp_blk_q.push_back(N1);
        exp_out_q.push_back(PT1 ^ N1 ^ MASK);
        do_cfg(N1);
        @(negedge clk);
        chk("t4_err_cleared", 128'(act_err), 128'h0);
        chk("t4_armed_not_busy", 128'(act_busy), 128'h0);
        chk("t4_fifo_head_kept", 128'(fifo_q.size()), 128'h1);
        wait_idle("t4_idle", 200);
        chk("t4_blk_count", 128'(act_bc), 128'h1);
`endif

        // core_done during START is ignored; reset in WAIT discards the block
        pulse_reset();
        sel       = 1'b0;
        core_mode = 2;
        do_cfg(N1);
        exp_blk_q.push_back(N1);
        fifo_q.push_back(PT1);
        g = go_cnt;
        n = 0;
        while (go_cnt == g && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_go_seen", 128'(n < 50), 128'h1);
        repeat (4) @(negedge clk);
        chk("t5_done_ignored", 128'(act_ov), 128'h0);
        chk("t5_busy_wait", 128'(act_busy), 128'h1);
        HRESETn = 1'b0;
        #1;
        chk("t5_rst_out_valid", 128'(act_ov), 128'h0);
        chk("t5_rst_busy", 128'(act_busy), 128'h0);
        chk("t5_rst_core_go", 128'(act_go), 128'h0);
        tick(2);
        fifo_q.delete();
        HRESETn   = 1'b1;
        core_mode = 0;
        tick(2);

        chk("end_exp_out_empty", 128'(exp_out_q.size()), 128'h0);
        chk("end_exp_blk_empty", 128'(exp_blk_q.size()), 128'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
